pipelined_accum: RTL and testbench

//   Downstream consumer of the pipelined adder result stream. Accepts 16-bit

---
 rtl/pipelined_accum.sv | 165 ++++++++++++++++
 tb/tb_pipelined_accum.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_accum.sv
// -----------------------------------------------------------------------------
// pipelined_accum
//   Frame accumulator that sits downstream of the pipelined adder result stream.
//   It sums each frame of COUNT accepted samples. The finished sum is then held
//   on a valid/ready output until it is drained. While a finished sum is
//   waiting, in_ready is low so that the producer stalls.
//
// Parameters
//   DATA_W  width of in_data (unsigned samples)
//   ACC_W   width of the accumulator and out_data; must be >= DATA_W
//   COUNT   accepted samples per frame; must be >= 1
//
// Ports
//   clk        in   single clock, all state updates on the rising edge
//   rst        in   synchronous, active-high reset
//   in_valid   in   in_data is valid this cycle
//   in_data    in   DATA_W-bit sample
//   in_ready   out  block accepts a sample this cycle (registered, state only)
//   out_valid  out  out_data holds a completed frame sum
//   out_data   out  ACC_W-bit frame sum
//   out_ready  in   consumer takes out_data this cycle
//
// Build option
//   PIPELINED_ACCUM_SAT_EN  when defined, additions clamp to all-ones on
//                           overflow. When undefined, they wrap modulo 2^ACC_W.
//                           Ports and timing are the same in both builds.
// -----------------------------------------------------------------------------
module pipelined_accum #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 24,
    parameter int COUNT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_data,
    input  logic              out_ready
);

    localparam int             CNT_W    = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // The sample is zero-extended. When saturation is enabled, a carry out of
    // ACC_W bits clamps the result to all-ones. An accumulator that is already
    // all-ones therefore stays all-ones for the rest of the frame.
    function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0]  a,
                                                 input logic [DATA_W-1:0] b);
`ifdef PIPELINED_ACCUM_SAT_EN
        logic [ACC_W:0] full;
        full = (ACC_W+1)'(a) + (ACC_W+1)'(b);
        if (full[ACC_W]) begin
            return {ACC_W{1'b1}};
        end else begin
            return full[ACC_W-1:0];
        end
`else
        return a + ACC_W'(b);
`endif
    endfunction

    state_t             state_r;
    state_t             state_nx_s;
    logic [ACC_W-1:0]   acc_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [ACC_W-1:0]   out_data_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               in_ready_nx_s;
    logic               out_valid_nx_s;
    logic               acc_fire_s;
    logic               last_s;
    logic [ACC_W-1:0]   sum_s;

    // Accept qualifier and running sum including the current sample
    always_comb begin
        acc_fire_s = in_valid & in_ready_r;
        last_s     = (cnt_r == LAST_CNT);
        sum_s      = acc_add(acc_r, in_data);
    end

    // Next-state logic: the last accepted sample of a frame moves to HOLD, and a drain returns to ACCUM
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_ACCUM: begin
                if (acc_fire_s && last_s) begin
                    state_nx_s = ST_HOLD;
                end else begin
                    state_nx_s = ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_nx_s = ST_ACCUM;
                end else begin
                    state_nx_s = ST_HOLD;
                end
            end
            default: state_nx_s = ST_ACCUM;
        endcase
    end

    // Output decode from the next state. The result is registered, so in_ready has no path from out_ready
    always_comb begin
        in_ready_nx_s  = 1'b1;
        out_valid_nx_s = 1'b0;
        case (state_nx_s)
            ST_ACCUM: begin
                in_ready_nx_s  = 1'b1;
                out_valid_nx_s = 1'b0;
            end
            ST_HOLD: begin
                in_ready_nx_s  = 1'b0;
                out_valid_nx_s = 1'b1;
            end
            default: begin
                in_ready_nx_s  = 1'b1;
                out_valid_nx_s = 1'b0;
            end
        endcase
    end

    // State, flag and datapath registers. Reset takes priority over every other input
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_ACCUM;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            acc_r       <= {ACC_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            out_data_r  <= {ACC_W{1'b0}};
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= in_ready_nx_s;
            out_valid_r <= out_valid_nx_s;
            if (acc_fire_s) begin
                if (last_s) begin
                    out_data_r <= sum_s;
                    acc_r      <= {ACC_W{1'b0}};
                    cnt_r      <= {CNT_W{1'b0}};
                end else begin
                    acc_r      <= sum_s;
                    cnt_r      <= cnt_r + CNT_W'(1);
                end
            end else begin
                acc_r      <= acc_r;
                cnt_r      <= cnt_r;
                out_data_r <= out_data_r;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

endmodule

// File: tb/tb_pipelined_accum.sv
// Bench for pipelined_accum. Three instances run side by side:
//   0: defaults (ACC_W=24, COUNT=4)
//   1: ACC_W=16, COUNT=2 (overflow)
//   2: COUNT=1
// A frame-level model keeps the accepted samples of each instance in a queue.
// The model also tracks whether a sum is being held. All outputs are compared
// on every falling edge, and literal checks pin the directed scenarios.
module tb_pipelined_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  iv;
    logic [2:0]  ordy;
    logic [15:0] id [3];

    logic        ov0, ov1, ov2, ir0, ir1, ir2;
    logic [23:0] od0, od2;
    logic [15:0] od1;

    int n_checks = 0;
    int n_fail   = 0;

    // frame-level model state
    bit          m_hold [3];
    longint      m_data [3];
    longint      m_q    [3][$];

    always #5 clk = ~clk;

    pipelined_accum #(.DATA_W(16), .ACC_W(24), .COUNT(4)) u0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(id[0]), .in_ready(ir0),
        .out_valid(ov0), .out_data(od0), .out_ready(ordy[0]));
    pipelined_accum #(.DATA_W(16), .ACC_W(16), .COUNT(2)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(id[1]), .in_ready(ir1),
        .out_valid(ov1), .out_data(od1), .out_ready(ordy[1]));
    pipelined_accum #(.DATA_W(16), .ACC_W(24), .COUNT(1)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_data(id[2]), .in_ready(ir2),
        .out_valid(ov2), .out_data(od2), .out_ready(ordy[2]));

    function automatic int accw(int i);
        return (i == 1) ? 16 : 24;
    endfunction

    function automatic int cnt_of(int i);
        return (i == 0) ? 4 : ((i == 1) ? 2 : 1);
    endfunction

    function automatic logic get_ov(int i);
        return (i == 0) ? ov0 : ((i == 1) ? ov1 : ov2);
    endfunction

    function automatic logic get_ir(int i);
        return (i == 0) ? ir0 : ((i == 1) ? ir1 : ir2);
    endfunction

    function automatic longint get_od(int i);
        return (i == 0) ? longint'(od0) : ((i == 1) ? longint'(od1) : longint'(od2));
    endfunction

    // Frame sum from the true total of the samples. All samples are
    // non-negative, so clamping any partial sum gives the same result as
    // clamping the total.
    function automatic longint frame_sum(int i);
        longint total = 0;
        longint maxv  = (longint'(1) << accw(i)) - 1;
        foreach (m_q[i][k]) total += m_q[i][k];
`ifdef PIPELINED_ACCUM_SAT_EN
        return (total > maxv) ? maxv : total;
`else
        return total & maxv;
`endif
    endfunction

    task automatic check(string name, longint act, longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one edge using the current inputs. Then run the
    // clock and compare every output.
    task automatic step();
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_hold[i] = 1'b0;
                m_data[i] = 0;
                m_q[i].delete();
            end else if (m_hold[i]) begin
                if (ordy[i]) m_hold[i] = 1'b0;
            end else if (iv[i]) begin
                m_q[i].push_back(longint'(id[i]));
                if (m_q[i].size() == cnt_of(i)) begin
                    m_data[i] = frame_sum(i);
                    m_q[i].delete();
                    m_hold[i] = 1'b1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("out_valid[%0d]", i), longint'(get_ov(i)), longint'(m_hold[i]));
            check($sformatf("in_ready[%0d]", i), longint'(get_ir(i)), longint'(!m_hold[i]));
            check($sformatf("out_data[%0d]", i), get_od(i), m_data[i]);
        end
    endtask

    task automatic idle();
        rst  = 1'b0;
        iv   = 3'b000;
        ordy = 3'b111;
        for (int i = 0; i < 3; i++) id[i] = 16'd0;
    endtask

    task automatic pulse_rst();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic feed(int i, int d);
        iv[i] = 1'b1;
        id[i] = 16'(d);
        step();
        iv[i] = 1'b0;
    endtask

    initial begin
        idle();
        // reset dominates garbage on the inputs
        rst   = 1'b1;
        iv    = 3'bxxx;
        id[0] = 16'hxxxx;
        step();
        step();
        check("reset_out_valid", longint'(ov0), 0);
        check("reset_in_ready", longint'(ir0), 1);
        check("reset_out_data", longint'(od0), 0);
        idle();

        // 1. frame sum
        pulse_rst();
        feed(0, 12); feed(0, 17); feed(0, 17); feed(0, 17);
        check("t1_out_valid", longint'(ov0), 1);
        check("t1_in_ready", longint'(ir0), 0);
        check("t1_sum", longint'(od0), 63);
        step();
        check("t1_drained_valid", longint'(ov0), 0);
        check("t1_ready_back", longint'(ir0), 1);

        // 2. gaps are neither counted nor added
        pulse_rst();
        feed(0, 10); id[0] = 16'd999; step();
        feed(0, 20); id[0] = 16'd999; step();
        check("t2_not_done", longint'(ov0), 0);
        feed(0, 30); feed(0, 40);
        check("t2_sum", longint'(od0), 100);

        // 3. backpressure
        pulse_rst();
        ordy[0] = 1'b0;
        feed(0, 1); feed(0, 2); feed(0, 3); feed(0, 4);
        iv[0] = 1'b1; id[0] = 16'd50;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t3_hold_valid", longint'(ov0), 1);
            check("t3_hold_data", longint'(od0), 10);
            check("t3_hold_ready", longint'(ir0), 0);
        end
        iv[0] = 1'b0; ordy[0] = 1'b1;
        step();
        feed(0, 5); feed(0, 5); feed(0, 5); feed(0, 5);
        check("t3_next_sum", longint'(od0), 20);

        // 4. overflow on the 16-bit instance
        pulse_rst();
        feed(1, 16'hFFFF); feed(1, 16'h0002);
`ifdef PIPELINED_ACCUM_SAT_EN
        check("t4_overflow", longint'(od1), 16'hFFFF);
`else
        check("t4_overflow", longint'(od1), 16'h0001);
`endif

        // 5. reset mid-frame discards the partial frame
        pulse_rst();
        feed(0, 7); feed(0, 7);
        rst = 1'b1; step(); rst = 1'b0;
        check("t5_rst_valid", longint'(ov0), 0);
        check("t5_rst_ready", longint'(ir0), 1);
        feed(0, 1); feed(0, 1); feed(0, 1); feed(0, 1);
        check("t5_sum", longint'(od0), 4);

        // 6. COUNT=1 alternates between accept and drain
        pulse_rst();
        iv[2] = 1'b1; id[2] = 16'd9;
        for (int k = 0; k < 4; k++) begin
            step();
            check("t6_pulse", longint'(ov2), ((k % 2) == 0) ? 1 : 0);
            check("t6_data", longint'(od2), 9);
        end
        idle();

        // randomized traffic on all instances
        for (int n = 0; n < 800; n++) begin
            rst  = ($urandom_range(0, 99) == 0);
            iv   = 3'($urandom);
            ordy = 3'($urandom) | 3'($urandom);
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 1) == 1) id[i] = 16'hFF00 | 16'($urandom_range(0, 255));
                else                           id[i] = 16'($urandom);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
